dual_fetch_queue: RTL

Two-wide instruction fetch buffer for the 2-way superscalar datapath. It sits directly upstream of the IF/ID boundary and the dual decoders. Each cycle it drives two sequential addresses (pc, pc+4) to the instruction memory and enqueues the returned instruction pair, tagged with PCs, into a circular queue. The decode stage pops 0, 1 or 2 entries per cycle, so a load/store or branch pairing conflict can issue one instruction and keep its partner. A branch redirect flushes the queue and restarts fetch.

---
 rtl/dual_fetch_queue.sv | 89 ++++++++
 1 files changed

// File: rtl/dual_fetch_queue.sv
// Two-wide instruction fetch queue: fetches pc/pc+4 each cycle into a circular
// buffer and presents the two oldest entries to the dual decoders.
module dual_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [63:0]             imem_addr0,
  output logic [63:0]             imem_addr1,
  input  logic [31:0]             imem_data0,
  input  logic [31:0]             imem_data1,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_pc,
  input  logic [1:0]              deq_count,
  output logic                    out_valid0,
  output logic                    out_valid1,
  output logic [31:0]             out_instr0,
  output logic [31:0]             out_instr1,
  output logic [63:0]             out_pc0,
  output logic [63:0]             out_pc1,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]   pc;
  logic [PW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count, count_next;
  logic [31:0]   instr [DEPTH];
  logic [63:0]   epc   [DEPTH];
  logic          fetch_en;
  logic [1:0]    deq_req, deq_eff;
  logic          unused_pc_lsbs;

  // Fetch space is judged on the start-of-cycle count; a same-cycle pop does not help.
  always_comb begin
    fetch_en       = (CW'(DEPTH) - count) >= CW'(2);
    deq_req        = (deq_count == 2'd3) ? 2'd2 : deq_count;
    deq_eff        = (count < CW'(deq_req)) ? count[1:0] : deq_req;
    count_next     = count + (fetch_en ? CW'(2) : '0) - CW'(deq_eff);
    head1          = head + PW'(1);
    tail1          = tail + PW'(1);
    unused_pc_lsbs = ^redirect_pc[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[63:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_eff);
      count <= count_next;
      if (fetch_en) begin
        tail <= tail + PW'(2);
        pc   <= pc + 64'd8;
      end
    end
  end

  // Entry storage needs no reset: slots beyond count are masked on the outputs.
  always_ff @(posedge clk) begin
    if (!redirect_valid && fetch_en) begin
      instr[tail]  <= imem_data0;
      epc[tail]    <= pc;
      instr[tail1] <= imem_data1;
      epc[tail1]   <= pc + 64'd4;
    end
  end

  always_comb begin
    imem_addr0 = pc;
    imem_addr1 = pc + 64'd4;
    occupancy  = count;
    out_valid0 = count >= CW'(1);
    out_valid1 = count >= CW'(2);
    out_instr0 = out_valid0 ? instr[head]  : '0;
    out_pc0    = out_valid0 ? epc[head]    : '0;
    out_instr1 = out_valid1 ? instr[head1] : '0;
    out_pc1    = out_valid1 ? epc[head1]   : '0;
  end
endmodule
